// File: rtl/pixel_arbiter.sv
// pixel_arbiter: two pixel sources share one VGA adapter plot port.
// A client locks the port for a whole drawing pass (until its done strobe);
// when both clients ask at once, round-robin priority decides the owner.
// The winner's pixel is registered onto x/y/colour/writeEn.
// Optional feature macro: PIXEL_ARB_CLIP_EN. It drops accepted pixels outside
// the X_MAX x Y_MAX screen and adds the 'dropped' output.
//
// Handshake: reqN is the client's valid and ackN is the combinational ready.
// A pixel transfers in any cycle where ackN=1. ackN can only be 1 while client
// N owns the lock, and it then simply follows reqN.
module pixel_arbiter #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
`ifdef PIXEL_ARB_CLIP_EN
    ,
    // The clip bounds only exist when clipping is built in.
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
`endif
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req0,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [C_W-1:0] colour0,
    input  logic           done0,
    output logic           ack0,
    input  logic           req1,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    input  logic [C_W-1:0] colour1,
    input  logic           done1,
    output logic           ack1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [C_W-1:0] colour,
    output logic           writeEn,
    output logic           busy,
`ifdef PIXEL_ARB_CLIP_EN
    output logic           dropped,
`endif
    output logic [1:0]     fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       prio;       // 0: client 0 wins a tie, 1: client 1 wins
    logic       prio_next;

    logic           accept;
    logic           keep;
    logic [X_W-1:0] sel_x;
    logic [Y_W-1:0] sel_y;
    logic [C_W-1:0] sel_colour;

    // State and priority registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
        end
    end

    // Next-state logic. A pass ends only on the owner's done. Priority then
    // passes to the other client, which takes over at once if it is waiting.
    always_comb begin
        state_next = state;
        prio_next  = prio;
        case (state)
            IDLE: begin
                if (req0 && req1) state_next = prio ? OWN1 : OWN0;
                else if (req0)    state_next = OWN0;
                else if (req1)    state_next = OWN1;
            end
            OWN0: begin
                if (done0) begin
                    prio_next  = 1'b1;
                    state_next = req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (done1) begin
                    prio_next  = 1'b0;
                    state_next = req0 ? OWN0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state. Acks are forced low during reset.
    always_comb begin
        ack0      = !reset && (state == OWN0) && req0;
        ack1      = !reset && (state == OWN1) && req1;
        busy      = (state != IDLE);
        fsm_state = state;
    end

    // Select the pixel being accepted and decide whether it reaches the screen.
    always_comb begin
        accept     = ack0 || ack1;
        sel_x      = ack1 ? x1 : x0;
        sel_y      = ack1 ? y1 : y0;
        sel_colour = ack1 ? colour1 : colour0;
`ifdef PIXEL_ARB_CLIP_EN
        keep       = (sel_x < X_W'(X_MAX)) && (sel_y < Y_W'(Y_MAX));
`else
        keep       = 1'b1;
`endif
    end

    // Plot port registers. The coordinates load only for a kept pixel and
    // hold otherwise. writeEn pulses once per kept pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
        end else begin
            writeEn <= accept && keep;
            if (accept && keep) begin
                x      <= sel_x;
                y      <= sel_y;
                colour <= sel_colour;
            end
        end
    end

`ifdef PIXEL_ARB_CLIP_EN
    // Report pixels that were acked but fell outside the screen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) dropped <= 1'b0;
        else       dropped <= accept && !keep;
    end
`endif

endmodule

// File: tb/tb_pixel_arbiter.sv
// Bench for pixel_arbiter. It uses a fixed table for the arbitration corners,
// hand-written sequences for reset, long passes, done filtering and clipping,
// and a random phase. All of it is checked against a lock/priority model.
module tb_pixel_arbiter;

    logic       clock;
    logic       reset;
    logic       req0, done0, ack0, req1, done1, ack1;
    logic [7:0] x0, x1, x;
    logic [6:0] y0, y1, y;
    logic [2:0] colour0, colour1, colour;
    logic       writeEn, busy;
    logic [1:0] fsm_state;
`ifdef PIXEL_ARB_CLIP_EN
    logic       dropped;
`endif

    pixel_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .x0(x0), .y0(y0), .colour0(colour0), .done0(done0), .ack0(ack0),
        .req1(req1), .x1(x1), .y1(y1), .colour1(colour1), .done1(done1), .ack1(ack1),
        .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy),
`ifdef PIXEL_ARB_CLIP_EN
        .dropped(dropped),
`endif
        .fsm_state(fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Model: owner is -1 (nobody), 0 or 1. pr is the client that wins a tie.
    int         m_own;
    int         m_pr;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;
    logic       m_we;
    logic       m_drop;

    typedef struct {
        logic r0, r1, d0, d1;
        logic ea0, ea1, ebusy, ewe;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_pr = 0;
        m_x = '0; m_y = '0; m_c = '0; m_we = 1'b0; m_drop = 1'b0;
    endtask

    // One clock cycle. Entered and left at posedge+1.
    task automatic cycle(input logic r0, input logic [7:0] a0, input logic [6:0] b0,
                         input logic [2:0] c0, input logic d0,
                         input logic r1, input logic [7:0] a1, input logic [6:0] b1,
                         input logic [2:0] c1, input logic d1,
                         output logic got_a0, output logic got_a1, output logic got_we);
        logic ea0, ea1, in_screen;
        req0 = r0; x0 = a0; y0 = b0; colour0 = c0; done0 = d0;
        req1 = r1; x1 = a1; y1 = b1; colour1 = c1; done1 = d1;
        #1;
        ea0 = (m_own == 0) && r0;
        ea1 = (m_own == 1) && r1;
        got_a0 = ack0; got_a1 = ack1;
        chk("ack0", ack0, ea0);
        chk("ack1", ack1, ea1);
        m_we = 1'b0; m_drop = 1'b0;
        if (ea0 || ea1) begin
`ifdef PIXEL_ARB_CLIP_EN
            in_screen = ea0 ? (a0 < 160 && b0 < 120) : (a1 < 160 && b1 < 120);
`else
            in_screen = 1'b1;
`endif
            if (in_screen) begin
                m_we = 1'b1;
                m_x = ea0 ? a0 : a1;
                m_y = ea0 ? b0 : b1;
                m_c = ea0 ? c0 : c1;
            end else begin
                m_drop = 1'b1;
            end
        end
        if (m_own == -1) begin
            if (r0 && r1) m_own = m_pr;
            else if (r0)  m_own = 0;
            else if (r1)  m_own = 1;
        end else if (m_own == 0 && d0) begin
            m_pr = 1; m_own = r1 ? 1 : -1;
        end else if (m_own == 1 && d1) begin
            m_pr = 0; m_own = r0 ? 0 : -1;
        end
        @(posedge clock); #1;
        got_we = writeEn;
        chk("writeEn", writeEn, m_we);
        chk("busy", busy, (m_own != -1));
        chk("x", x, m_x);
        chk("y", y, m_y);
        chk("colour", colour, m_c);
`ifdef PIXEL_ARB_CLIP_EN
        chk("dropped", dropped, m_drop);
`endif
    endtask

    task automatic idle_cycle();
        logic g0, g1, gw;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1, gw);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_writeEn", writeEn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_ack0", ack0, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic g0, g1, gw;
        int   we_cnt, a1_cnt;

        // Arbitration corners, starting from reset: rows 0-5 cover the tie and
        // the hand-over with no idle gap, rows 6-9 the flipped priority.
        tbl[0] = '{1,1,0,0, 0,0,1,0};
        tbl[1] = '{1,1,0,0, 1,0,1,1};
        tbl[2] = '{1,1,1,0, 1,0,1,1};
        tbl[3] = '{0,1,0,0, 0,1,1,1};
        tbl[4] = '{1,1,0,1, 0,1,1,1};
        tbl[5] = '{1,0,1,0, 1,0,0,1};
        tbl[6] = '{1,1,0,0, 0,0,1,0};
        tbl[7] = '{1,1,0,0, 0,1,1,1};
        tbl[8] = '{0,0,0,1, 0,0,0,0};
        tbl[9] = '{0,0,0,0, 0,0,0,0};

        reset = 1'b1;
        req0 = 0; x0 = 0; y0 = 0; colour0 = 0; done0 = 0;
        req1 = 0; x1 = 0; y1 = 0; colour1 = 0; done1 = 0;
        @(posedge clock); #1;
        do_reset();

        // Reset in the middle of a pass.
        cycle(1, 8'd5, 7'd6, 3'd7, 0, 0, 0, 0, 0, 0, g0, g1, gw);
        cycle(1, 8'd5, 7'd6, 3'd7, 0, 0, 0, 0, 0, 0, g0, g1, gw);
        chk("midpass_we_before", writeEn, 1);
        do_reset();
        idle_cycle();
        chk("post_reset_state_idle", fsm_state, 2'd0);

        // Table-driven arbitration vectors.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].r0, 8'(10 + i), 7'(20 + i), 3'(i), tbl[i].d0,
                  tbl[i].r1, 8'(100 + i), 7'(50 + i), 3'(7 - i), tbl[i].d1, g0, g1, gw);
            chk($sformatf("tbl%0d_ack0", i), g0, tbl[i].ea0);
            chk($sformatf("tbl%0d_ack1", i), g1, tbl[i].ea1);
            chk($sformatf("tbl%0d_we", i), gw, tbl[i].ewe);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
        end

        // A long single-client pass: 200 pixels, done on the last one.
        we_cnt = 0; a1_cnt = 0;
        cycle(1, 8'd60, 7'd40, 3'b100, 0, 0, 0, 0, 0, 0, g0, g1, gw);
        for (int i = 0; i < 200; i++) begin
            cycle(1, 8'(60 + i % 40), 7'(40 + i / 40), 3'b100, (i == 199),
                  0, 8'd1, 7'd1, 3'd1, 0, g0, g1, gw);
            if (gw) we_cnt++;
            if (g1) a1_cnt++;
        end
        chk("pass_we_count", we_cnt, 200);
        chk("pass_ack1_count", a1_cnt, 0);
        chk("pass_idle_busy", busy, 0);
        chk("pass_last_x", x, 8'd99);
        chk("pass_last_y", y, 7'd44);

        // A done from the non-owner is ignored, and the lock holds while req is low.
        cycle(1, 8'd1, 7'd2, 3'd3, 0, 0, 0, 0, 0, 0, g0, g1, gw);
        cycle(1, 8'd1, 7'd2, 3'd3, 0, 0, 0, 0, 0, 1, g0, g1, gw);
        chk("foreign_done_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 8'd9, 7'd9, 3'd1, 0, 0, 0, 0, 0, 0, g0, g1, gw);
            chk("hold_we", gw, 0);
            chk("hold_busy", busy, 1);
        end

        // Clip boundary cases with client 0 still owning.
        cycle(1, 8'd160, 7'd10, 3'd7, 0, 0, 0, 0, 0, 0, g0, g1, gw);
        chk("clip_ack0", g0, 1);
`ifdef PIXEL_ARB_CLIP_EN
        chk("clip_we", gw, 0);
        chk("clip_dropped", dropped, 1);
`else
        chk("noclip_we", gw, 1);
        chk("noclip_x", x, 8'd160);
`endif
        cycle(1, 8'd159, 7'd119, 3'd7, 1, 0, 0, 0, 0, 0, g0, g1, gw);
        chk("edge_we", gw, 1);
        chk("edge_x", x, 8'd159);
        chk("edge_y", y, 7'd119);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 7'($urandom), 3'($urandom),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, 8'($urandom), 7'($urandom), 3'($urandom),
                  $urandom_range(0, 9) == 0, g0, g1, gw);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
